// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, load funct3 codes and the
// writeback FSM state type.
package core_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;

    // Bytes per data word; the load byte offset is taken modulo this.
    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;

    // Load funct3 encodings.
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the byte/halfword/word addressed by the low address
// bits out of a data-memory word and sign- or zero-extends it.
//   rdata_i    data-memory response word
//   funct3_i   load size/sign code
//   offset_i   low address bits (truncated to the word's byte-offset range)
//   ext_data_o aligned, extended result (0 for unsupported codes)
module load_align
    import core_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [2:0]            funct3_i,
    input  logic [2:0]            offset_i,
    output logic [DATA_WIDTH-1:0] ext_data_o
);

    logic [2:0]            off;
    logic [2:0]            off_h;
    logic [2:0]            off_w;
    logic [DATA_WIDTH-1:0] byte_w;
    logic [DATA_WIDTH-1:0] half_w;
    logic [DATA_WIDTH-1:0] word_w;

    always_comb begin
        // Misaligned accesses never reach here; just drop bits above the word.
        off    = offset_i & 3'(DATA_BYTES - 1);
        off_h  = off & 3'b110;
        off_w  = off & 3'b100;
        byte_w = rdata_i >> {off, 3'b000};
        half_w = rdata_i >> {off_h, 3'b000};
        word_w = rdata_i >> {off_w, 3'b000};

        ext_data_o = '0;
        case (funct3_i)
            LB:  ext_data_o = DATA_WIDTH'($signed(byte_w[7:0]));
            LBU: ext_data_o = DATA_WIDTH'(byte_w[7:0]);
            LH:  ext_data_o = DATA_WIDTH'($signed(half_w[15:0]));
            LHU: ext_data_o = DATA_WIDTH'(half_w[15:0]);
            LW:  ext_data_o = DATA_WIDTH'($signed(word_w[31:0]));
            LWU: begin
                if (DATA_WIDTH == 64) ext_data_o = DATA_WIDTH'(word_w[31:0]);
            end
            LD: begin
                if (DATA_WIDTH == 64) ext_data_o = rdata_i;
            end
            default: ext_data_o = '0;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Writeback stage: final pipeline stage ahead of the GPR write port.
// Accepts completed instructions over valid/ready, waits for the data-memory
// response on loads, and issues a registered one-cycle GPR write request.
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   valid_i / ready_o    handshake from the memory stage
//   rd_i, exe_data_i     destination register and non-load result
//   is_load_i, funct3_i, addr_lsb_i   load descriptor
//   rdata_valid_i, rdata_i            data-memory response
//   wb_valid_o, rd_o, rd_data_o       GPR write request (pulse)
//   instret_o            retired-instruction counter (wraps)
module writeback
    import core_pkg::*;
#(
    parameter int unsigned INSTRET_WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [RF_ADDR_WIDTH-1:0] rd_i,
    input  logic [DATA_WIDTH-1:0]    exe_data_i,
    input  logic                     is_load_i,
    input  logic [2:0]               funct3_i,
    input  logic [2:0]               addr_lsb_i,
    input  logic                     rdata_valid_i,
    input  logic [DATA_WIDTH-1:0]    rdata_i,
    output logic                     wb_valid_o,
    output logic [RF_ADDR_WIDTH-1:0] rd_o,
    output logic [DATA_WIDTH-1:0]    rd_data_o,
    output logic [INSTRET_WIDTH-1:0] instret_o
);

    wb_state_t                state_q;
    logic [RF_ADDR_WIDTH-1:0] ld_rd_q;
    logic [2:0]               ld_funct3_q;
    logic [2:0]               ld_off_q;
    logic                     wb_valid_q;
    logic [RF_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]    rd_data_q;
    logic [INSTRET_WIDTH-1:0] instret_q;
    logic [DATA_WIDTH-1:0]    ld_data;

    load_align u_load_align (
        .rdata_i    (rdata_i),
        .funct3_i   (ld_funct3_q),
        .offset_i   (ld_off_q),
        .ext_data_o (ld_data)
    );

    assign ready_o = (state_q == WB_IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= WB_IDLE;
            ld_rd_q     <= '0;
            ld_funct3_q <= '0;
            ld_off_q    <= '0;
            wb_valid_q  <= 1'b0;
            rd_q        <= '0;
            rd_data_q   <= '0;
            instret_q   <= '0;
        end else begin
            // Write request is a pulse; only a commit raises it.
            wb_valid_q <= 1'b0;
            case (state_q)
                WB_IDLE: begin
                    if (valid_i) begin
                        if (is_load_i) begin
                            ld_rd_q     <= rd_i;
                            ld_funct3_q <= funct3_i;
                            ld_off_q    <= addr_lsb_i;
                            state_q     <= WB_WAIT_LOAD;
                        end else begin
                            // x0 commits and counts but is never written.
                            wb_valid_q <= (rd_i != '0);
                            rd_q       <= rd_i;
                            rd_data_q  <= exe_data_i;
                            instret_q  <= instret_q + 1'b1;
                        end
                    end
                end
                WB_WAIT_LOAD: begin
                    if (rdata_valid_i) begin
                        wb_valid_q <= (ld_rd_q != '0);
                        rd_q       <= ld_rd_q;
                        rd_data_q  <= ld_data;
                        instret_q  <= instret_q + 1'b1;
                        state_q    <= WB_IDLE;
                    end
                end
                default: state_q <= WB_IDLE;
            endcase
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign rd_o       = rd_q;
    assign rd_data_o  = rd_data_q;
    assign instret_o  = instret_q;

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;
    import core_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rstn_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [RF_ADDR_WIDTH-1:0] rd_i;
    logic [DATA_WIDTH-1:0]    exe_data_i;
    logic                     is_load_i;
    logic [2:0]               funct3_i;
    logic [2:0]               addr_lsb_i;
    logic                     rdata_valid_i;
    logic [DATA_WIDTH-1:0]    rdata_i;
    logic                     wb_valid_o;
    logic [RF_ADDR_WIDTH-1:0] rd_o;
    logic [DATA_WIDTH-1:0]    rd_data_o;
    logic [63:0]              instret_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_busy;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [2:0]  m_off;
    logic        e_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [63:0] e_instret;

    always #5 clk_i = ~clk_i;

    writeback #(.INSTRET_WIDTH(64)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .rd_i          (rd_i),
        .exe_data_i    (exe_data_i),
        .is_load_i     (is_load_i),
        .funct3_i      (funct3_i),
        .addr_lsb_i    (addr_lsb_i),
        .rdata_valid_i (rdata_valid_i),
        .rdata_i       (rdata_i),
        .wb_valid_o    (wb_valid_o),
        .rd_o          (rd_o),
        .rd_data_o     (rd_data_o),
        .instret_o     (instret_o)
    );

    // RV32 load semantics from first principles: size in bytes, naturally
    // aligned base, extract by division/modulo, sign-extend arithmetically.
    function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [2:0] lsb);
        longint unsigned size, off, base, v, lim;
        bit sgn;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd4: begin size = 1; sgn = 0; end
            3'd1: begin size = 2; sgn = 1; end
            3'd5: begin size = 2; sgn = 0; end
            3'd2: begin size = 4; sgn = 1; end
            default: return 32'd0;
        endcase
        off  = longint'(lsb) % 4;
        base = off - (off % size);
        lim  = 64'd1 << (8 * size);
        v    = (longint'(w) / (64'd1 << (8 * base))) % lim;
        if (sgn && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_rd = 0; m_f3 = 0; m_off = 0;
        e_wb = 0; e_rd = 0; e_data = 0; e_instret = 0;
    endtask

    // One clock: check ready before the edge, advance the model, check after.
    task automatic cycle();
        chk("ready", 64'(ready_o), 64'(!m_busy));
        @(posedge clk_i);
        e_wb = 0;
        if (!m_busy) begin
            if (valid_i) begin
                if (is_load_i) begin
                    m_busy = 1; m_rd = rd_i; m_f3 = funct3_i; m_off = addr_lsb_i;
                end else begin
                    e_wb = (rd_i != 0); e_rd = rd_i; e_data = exe_data_i;
                    e_instret = e_instret + 1;
                end
            end
        end else if (rdata_valid_i) begin
            e_wb = (m_rd != 0); e_rd = m_rd; e_data = ref_align(rdata_i, m_f3, m_off);
            e_instret = e_instret + 1;
            m_busy = 0;
        end
        #1;
        chk("wb_valid", 64'(wb_valid_o), 64'(e_wb));
        chk("rd", 64'(rd_o), 64'(e_rd));
        chk("rd_data", 64'(rd_data_o), 64'(e_data));
        chk("instret", instret_o, e_instret);
    endtask

    task automatic idle_inputs();
        valid_i = 0; is_load_i = 0; rd_i = 0; exe_data_i = 0; funct3_i = 0;
        addr_lsb_i = 0; rdata_valid_i = 0; rdata_i = 0;
    endtask

    initial begin
        idle_inputs();
        rstn_i = 0;
        model_reset();
        #12;
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        @(negedge clk_i);
        rstn_i = 1;
        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_rd_data", 64'(rd_data_o), 64'd0);
        cycle();

        // Three back-to-back non-loads
        valid_i = 1; is_load_i = 0; rd_i = 5; exe_data_i = 32'h1234;
        repeat (3) begin
            cycle();
            chk("b2b_wb", 64'(wb_valid_o), 64'd1);
            chk("b2b_data", 64'(rd_data_o), 64'h1234);
        end
        idle_inputs();
        cycle();
        chk("b2b_instret", instret_o, 64'd3);

        // LB off=3, response the cycle after accept
        valid_i = 1; is_load_i = 1; funct3_i = LB; addr_lsb_i = 3'd3; rd_i = 7;
        cycle();
        idle_inputs();
        rdata_valid_i = 1; rdata_i = 32'h80FF_0000;
        cycle();
        chk("lb_data", 64'(rd_data_o), 64'hFFFF_FF80);
        rdata_valid_i = 0;
        cycle();
        chk("lb_pulse", 64'(wb_valid_o), 64'd0);

        // LHU off=2, response delayed 4 cycles
        valid_i = 1; is_load_i = 1; funct3_i = LHU; addr_lsb_i = 3'd2; rd_i = 9;
        cycle();
        idle_inputs();
        rdata_i = 32'hBEEF_1234;
        repeat (4) cycle();
        rdata_valid_i = 1;
        cycle();
        chk("lhu_data", 64'(rd_data_o), 64'h0000_BEEF);
        idle_inputs();

        // Non-load to x0
        valid_i = 1; rd_i = 0; exe_data_i = 32'hDEAD_BEEF;
        cycle();
        chk("x0_wb", 64'(wb_valid_o), 64'd0);
        chk("x0_instret", instret_o, 64'd6);
        idle_inputs();

        // Reset while waiting on a load
        valid_i = 1; is_load_i = 1; funct3_i = LW; rd_i = 3;
        cycle();
        idle_inputs();
        cycle();
        #2;
        rstn_i = 0;
        #1;
        model_reset();
        chk("mid_rst_ready", 64'(ready_o), 64'd1);
        chk("mid_rst_instret", instret_o, 64'd0);
        chk("mid_rst_rd", 64'(rd_o), 64'd0);
        rdata_valid_i = 1; rdata_i = 32'h1111_2222;
        @(negedge clk_i);
        rstn_i = 1;
        repeat (2) cycle();
        chk("post_rst_instret", instret_o, 64'd0);
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            valid_i       = ($urandom_range(0, 9) < 7);
            is_load_i     = ($urandom_range(0, 9) < 4);
            rd_i          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            exe_data_i    = $urandom;
            funct3_i      = 3'($urandom);
            addr_lsb_i    = 3'($urandom);
            rdata_valid_i = ($urandom_range(0, 9) < 4);
            rdata_i       = $urandom;
            cycle();
        end
        idle_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
